// File: rtl/commit_perf_if.sv
// commit_perf_if
//   Bundles the commit-stage debug bus and the readout signals of the
//   commit performance monitor.
//   Control : start, clear, end_req
//   Commit  : commit_valid[NUM_CH], commit_pc[NUM_CH*32],
//             commit_br_op[NUM_CH], commit_pred_ok[NUM_CH]
//   Readout : running, done, done_pulse, cycle_cnt, inst_cnt,
//             ch_inst_cnt[NUM_CH*CNT_W], br_cnt, br_hit_cnt, overflow
//   master drives control/commit and reads the readout; slave is the monitor.
interface commit_perf_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32
);
    logic                      start;
    logic                      clear;
    logic                      end_req;
    logic [NUM_CH-1:0]         commit_valid;
    logic [NUM_CH*32-1:0]      commit_pc;
    logic [NUM_CH-1:0]         commit_br_op;
    logic [NUM_CH-1:0]         commit_pred_ok;
    logic                      running;
    logic                      done;
    logic                      done_pulse;
    logic [CNT_W-1:0]          cycle_cnt;
    logic [CNT_W-1:0]          inst_cnt;
    logic [NUM_CH*CNT_W-1:0]   ch_inst_cnt;
    logic [CNT_W-1:0]          br_cnt;
    logic [CNT_W-1:0]          br_hit_cnt;
    logic                      overflow;

    modport master (
        output start, clear, end_req, commit_valid, commit_pc, commit_br_op, commit_pred_ok,
        input  running, done, done_pulse, cycle_cnt, inst_cnt, ch_inst_cnt,
               br_cnt, br_hit_cnt, overflow
    );

    modport slave (
        input  start, clear, end_req, commit_valid, commit_pc, commit_br_op, commit_pred_ok,
        output running, done, done_pulse, cycle_cnt, inst_cnt, ch_inst_cnt,
               br_cnt, br_hit_cnt, overflow
    );
endinterface

// File: rtl/commit_perf_monitor.sv
// commit_perf_monitor
//   Commit-stage performance monitor for an N-issue core. While running it
//   counts cycles, retired instructions (total and per channel), branches and
//   correctly predicted branches, all with saturation and a sticky overflow.
//   A commit of END_PC or an external end request stops the run and freezes
//   the counters for readout.
//   clk   : core clock
//   reset : synchronous, active-high
//   bus   : commit_perf_if slave (control, commit debug bus, readout)
module commit_perf_monitor #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32,
    parameter logic [31:0] END_PC = 32'hbfc00100
) (
    input  logic         clk,
    input  logic         reset,
    commit_perf_if.slave bus
);
    localparam int unsigned PW = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_end_hit;
    logic [PW-1:0]    w_pop_inst;
    logic [PW-1:0]    w_pop_br;
    logic [PW-1:0]    w_pop_hit;
    logic [CNT_W:0]   w_cycle_s;
    logic [CNT_W:0]   w_inst_s;
    logic [CNT_W:0]   w_br_s;
    logic [CNT_W:0]   w_hit_s;
    logic [CNT_W:0]   w_ch_s [NUM_CH];
    logic             w_any_ovf;

    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_inst;
    logic [CNT_W-1:0] r_br;
    logic [CNT_W-1:0] r_hit;
    logic [CNT_W-1:0] r_ch [NUM_CH];
    logic             r_ovf;
    logic             r_done_pulse;

    // Result MSB flags a clamp; the low CNT_W bits hold the saturated sum.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) begin
            s = {1'b1, {CNT_W{1'b1}}};
        end
        return s;
    endfunction

    always_comb begin
        w_end_hit  = bus.end_req;
        w_pop_inst = '0;
        w_pop_br   = '0;
        w_pop_hit  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.commit_valid[i] && (bus.commit_pc[i*32 +: 32] == END_PC)) begin
                w_end_hit = 1'b1;
            end
            w_pop_inst = w_pop_inst + PW'(bus.commit_valid[i]);
            w_pop_br   = w_pop_br   + PW'(bus.commit_valid[i] & bus.commit_br_op[i]);
            w_pop_hit  = w_pop_hit  + PW'(bus.commit_valid[i] & bus.commit_br_op[i]
                                          & bus.commit_pred_ok[i]);
        end
    end

    always_comb begin
        w_cycle_s = sat_add(r_cycle, CNT_W'(1));
        w_inst_s  = sat_add(r_inst,  CNT_W'(w_pop_inst));
        w_br_s    = sat_add(r_br,    CNT_W'(w_pop_br));
        w_hit_s   = sat_add(r_hit,   CNT_W'(w_pop_hit));
        w_any_ovf = w_cycle_s[CNT_W] | w_inst_s[CNT_W] | w_br_s[CNT_W] | w_hit_s[CNT_W];
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_ch_s[i] = sat_add(r_ch[i], CNT_W'(bus.commit_valid[i]));
            w_any_ovf = w_any_ovf | w_ch_s[i][CNT_W];
        end
    end

    // clear overrides every transition, including a same-cycle end hit.
    always_comb begin
        w_next = r_state;
        if (bus.clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_next = S_RUN;
                S_RUN:   if (w_end_hit) w_next = S_DONE;
                S_DONE:  w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_done_pulse <= (r_state == S_RUN) && (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_cycle <= '0;
            r_inst  <= '0;
            r_br    <= '0;
            r_hit   <= '0;
            r_ovf   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_ch[i] <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_cycle <= w_cycle_s[CNT_W-1:0];
            r_inst  <= w_inst_s[CNT_W-1:0];
            r_br    <= w_br_s[CNT_W-1:0];
            r_hit   <= w_hit_s[CNT_W-1:0];
            r_ovf   <= r_ovf | w_any_ovf;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_ch[i] <= w_ch_s[i][CNT_W-1:0];
            end
        end
    end

    assign bus.running    = (r_state == S_RUN);
    assign bus.done       = (r_state == S_DONE);
    assign bus.done_pulse = r_done_pulse;
    assign bus.cycle_cnt  = r_cycle;
    assign bus.inst_cnt   = r_inst;
    assign bus.br_cnt     = r_br;
    assign bus.br_hit_cnt = r_hit;
    assign bus.overflow   = r_ovf;

    always_comb begin
        bus.ch_inst_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.ch_inst_cnt[i*CNT_W +: CNT_W] = r_ch[i];
        end
    end
endmodule
